mem_bus_arbiter: RTL and testbench

//  Shares the single memory-mapped bus (ROM 0x0000-0x1FFF, RAM 0x2000-0x2FFF, UART data 0x3000,

---
 rtl/mem_bus_arbiter_if.sv | 47 ++++
 rtl/mem_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesters (M0 CPU, M1 DMA), the arbiter and
// the address decoder / target read-data mux.
interface mem_bus_arbiter_if #(
  parameter int DATA_W = 32
) ();

  logic              m0_req;
  logic [31:0]       m0_addr;
  logic              m0_we;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic              m0_err;

  logic              m1_req;
  logic [31:0]       m1_addr;
  logic              m1_we;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic              m1_err;

  logic [DATA_W-1:0] rdata;
  logic [31:0]       bus_addr;
  logic              bus_we;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;

  // Arbiter side: takes requests and target read data, drives acks and the bus.
  modport slave (
    input  m0_req, m0_addr, m0_we, m0_wdata,
    output m0_ack, m0_err,
    input  m1_req, m1_addr, m1_we, m1_wdata,
    output m1_ack, m1_err,
    output rdata, bus_addr, bus_we, bus_wdata,
    input  bus_rdata
  );

  // Environment side: the requesters plus the decoder/target read-data mux.
  modport master (
    output m0_req, m0_addr, m0_we, m0_wdata,
    input  m0_ack, m0_err,
    output m1_req, m1_addr, m1_we, m1_wdata,
    input  m1_ack, m1_err,
    input  rdata, bus_addr, bus_we, bus_wdata,
    output bus_rdata
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared memory-mapped bus.
// One access at a time: IDLE grants, ACCESS holds the bus for 1+WS cycles,
// DONE pulses the owner's ack. Illegal accesses skip ACCESS and ack with err.
module mem_bus_arbiter #(
  parameter int WS_ROM  = 1,
  parameter int WS_RAM  = 0,
  parameter int WS_UART = 1,
  parameter int DATA_W  = 32
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_arbiter_if.slave mbus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    RG_ROM   = 3'd0,
    RG_RAM   = 3'd1,
    RG_UDATA = 3'd2,
    RG_USTAT = 3'd3,
    RG_NONE  = 3'd4
  } region_t;

  // Address map decode.
  function automatic region_t decode(input logic [31:0] addr);
    region_t r;
    if (addr < 32'h0000_2000) begin
      r = RG_ROM;
    end else if (addr < 32'h0000_3000) begin
      r = RG_RAM;
    end else if (addr == 32'h0000_3000) begin
      r = RG_UDATA;
    end else if (addr == 32'h0000_3004) begin
      r = RG_USTAT;
    end else begin
      r = RG_NONE;
    end
    return r;
  endfunction

  // Accesses that never reach the bus: ROM/status writes, unmapped anything.
  function automatic logic rejected(input region_t r, input logic we);
    logic bad;
    case (r)
      RG_ROM:   bad = we;
      RG_RAM:   bad = 1'b0;
      RG_UDATA: bad = 1'b0;
      RG_USTAT: bad = we;
      RG_NONE:  bad = 1'b1;
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Extra wait cycles per region, loaded into the ACCESS down-counter.
  function automatic logic [7:0] wait_states(input region_t r);
    logic [7:0] ws;
    case (r)
      RG_ROM:   ws = 8'(WS_ROM);
      RG_RAM:   ws = 8'(WS_RAM);
      RG_UDATA: ws = 8'(WS_UART);
      RG_USTAT: ws = 8'(WS_UART);
      default:  ws = 8'd0;
    endcase
    return ws;
  endfunction

  state_t            state_r;
  logic [7:0]        cnt_r;
  logic              last_grant_r;   // 1 = M1 was granted last
  logic              grant_r;        // owner of the access in flight (1 = M1)

  logic              any_req_s;
  logic              sel_m1_s;
  logic [31:0]       sel_addr_s;
  logic              sel_we_s;
  logic [DATA_W-1:0] sel_wdata_s;
  region_t           sel_region_s;
  logic              sel_err_s;

  // Pick the winner: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    any_req_s = mbus.m0_req | mbus.m1_req;
    sel_m1_s  = 1'b0;
    if (mbus.m0_req && mbus.m1_req) begin
      sel_m1_s = ~last_grant_r;
    end else if (mbus.m1_req) begin
      sel_m1_s = 1'b1;
    end else begin
      sel_m1_s = 1'b0;
    end
    if (sel_m1_s) begin
      sel_addr_s  = mbus.m1_addr;
      sel_we_s    = mbus.m1_we;
      sel_wdata_s = mbus.m1_wdata;
    end else begin
      sel_addr_s  = mbus.m0_addr;
      sel_we_s    = mbus.m0_we;
      sel_wdata_s = mbus.m0_wdata;
    end
    sel_region_s = decode(sel_addr_s);
    sel_err_s    = rejected(sel_region_s, sel_we_s);
  end

  // Access sequencer: grant, hold bus for the wait states, then pulse ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 8'd0;
      last_grant_r   <= 1'b1;
      grant_r        <= 1'b0;
      mbus.bus_addr  <= 32'd0;
      mbus.bus_we    <= 1'b0;
      mbus.bus_wdata <= {DATA_W{1'b0}};
      mbus.rdata     <= {DATA_W{1'b0}};
      mbus.m0_ack    <= 1'b0;
      mbus.m0_err    <= 1'b0;
      mbus.m1_ack    <= 1'b0;
      mbus.m1_err    <= 1'b0;
    end else begin
      // Acks are single-cycle pulses; only the transition into DONE sets them.
      mbus.m0_ack <= 1'b0;
      mbus.m0_err <= 1'b0;
      mbus.m1_ack <= 1'b0;
      mbus.m1_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          mbus.bus_we <= 1'b0;
          if (any_req_s) begin
            last_grant_r <= sel_m1_s;
            grant_r      <= sel_m1_s;
            if (sel_err_s) begin
              // Rejected: bus untouched, straight to DONE with err.
              if (sel_m1_s) begin
                mbus.m1_ack <= 1'b1;
                mbus.m1_err <= 1'b1;
              end else begin
                mbus.m0_ack <= 1'b1;
                mbus.m0_err <= 1'b1;
              end
              mbus.rdata <= {DATA_W{1'b0}};
              state_r    <= ST_DONE;
            end else begin
              mbus.bus_addr  <= sel_addr_s;
              mbus.bus_we    <= sel_we_s;
              mbus.bus_wdata <= sel_wdata_s;
              cnt_r          <= wait_states(sel_region_s);
              state_r        <= ST_ACCESS;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (cnt_r == 8'd0) begin
            // Only reads update rdata; writes leave the last read value.
            if (!mbus.bus_we) begin
              mbus.rdata <= mbus.bus_rdata;
            end
            mbus.bus_we <= 1'b0;
            if (grant_r) begin
              mbus.m1_ack <= 1'b1;
            end else begin
              mbus.m0_ack <= 1'b1;
            end
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        ST_DONE: begin
          mbus.bus_we <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          mbus.bus_we <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: each request pushes its expectation
// into the owning master's queue; the ack monitor pops and compares.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   we_cnt = 0;
  logic [31:0] last_rd = 32'd0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          raise;
    int          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ord[$];

  mem_bus_arbiter_if #(.DATA_W(32)) bif ();

  mem_bus_arbiter #(
    .WS_ROM (1),
    .WS_RAM (0),
    .WS_UART(1),
    .DATA_W (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mbus (bif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Target read data: a fixed pattern per address, 0xDEADBEEF at 0x10.
  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] v;
    if (a == 32'h0000_0010) v = 32'hDEAD_BEEF;
    else v = {a[15:0] ^ 16'h5A5A, a[15:0]};
    return v;
  endfunction

  function automatic logic exp_err(input logic [31:0] a, input logic we);
    logic e;
    if (a < 32'h0000_2000) e = we;
    else if (a < 32'h0000_3000) e = 1'b0;
    else if (a == 32'h0000_3000) e = 1'b0;
    else if (a == 32'h0000_3004) e = we;
    else e = 1'b1;
    return e;
  endfunction

  function automatic int exp_ws(input logic [31:0] a);
    int w;
    if (a < 32'h0000_2000) w = 1;
    else if (a < 32'h0000_3000) w = 0;
    else w = 1;
    return w;
  endfunction

  assign bif.bus_rdata = model_rd(bif.bus_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
  endtask

  // Pop the owner's expectation and compare everything visible in the ack cycle.
  task automatic check_ack(input int m);
    exp_t        e;
    logic        err;
    logic [31:0] er;
    logic        got_err;
    string       p;
    p = $sformatf("m%0d", m);
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      chk({p, "_spurious_ack"}, 32'd1, 32'd0);
    end else begin
      if (m == 0) begin
        e = q0.pop_front();
        got_err = bif.m0_err;
      end else begin
        e = q1.pop_front();
        got_err = bif.m1_err;
      end
      err = exp_err(e.addr, e.we);
      if (err) er = 32'd0;
      else if (!e.we) er = model_rd(e.addr);
      else er = last_rd;
      last_rd = er;
      chk({p, "_err"}, {31'd0, got_err}, {31'd0, err});
      chk({p, "_rdata"}, bif.rdata, er);
      chk({p, "_we_cycles"}, we_cnt, (err || !e.we) ? 32'd0 : 32'(1 + exp_ws(e.addr)));
      if (!err) chk({p, "_bus_addr"}, bif.bus_addr, e.addr);
      if (!err && e.we) chk({p, "_bus_wdata"}, bif.bus_wdata, e.wdata);
      if (e.lat >= 0) chk({p, "_latency"}, cyc - e.raise, e.lat);
      if (ord.size() > 0) chk({p, "_grant_order"}, m, ord.pop_front());
    end
    we_cnt = 0;
  endtask

  // Ack monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      we_cnt = 0;
    end else begin
      if (bif.bus_we) we_cnt++;
      if (bif.m0_ack && bif.m1_ack) chk("dual_ack", 32'd1, 32'd0);
      if (bif.m0_ack) check_ack(0);
      if (bif.m1_ack) check_ack(1);
    end
  end

  // Raise a request, hold it until the owner's ack (bounded), then drop it.
  // solo: the arbiter is idle and the request wins at once, so latency is known.
  task automatic issue(input int m, input logic [31:0] addr, input logic we,
                       input logic [31:0] wdata, input bit solo);
    exp_t e;
    bit   got;
    e.addr  = addr;
    e.we    = we;
    e.wdata = wdata;
    e.raise = cyc;
    e.lat   = solo ? (exp_err(addr, we) ? 1 : 2 + exp_ws(addr)) : -1;
    if (m == 0) begin
      q0.push_back(e);
      bif.m0_addr = addr; bif.m0_we = we; bif.m0_wdata = wdata; bif.m0_req = 1'b1;
    end else begin
      q1.push_back(e);
      bif.m1_addr = addr; bif.m1_we = we; bif.m1_wdata = wdata; bif.m1_req = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = (m == 0) ? bif.m0_ack : bif.m1_ack;
    end
    if (!got) chk($sformatf("m%0d_ack_timeout", m), 32'd0, 32'd1);
    if (m == 0) bif.m0_req = 1'b0;
    else bif.m1_req = 1'b0;
  endtask

  int          t_m   [11] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
  logic [31:0] t_addr[11] = '{32'h0000_0010, 32'h0000_2004, 32'h0000_0100, 32'h0000_3008,
                              32'h0000_3004, 32'h0000_3004, 32'h0000_1FFC, 32'h0000_2FFC,
                              32'h0000_3000, 32'hFFFF_0000, 32'h0000_2000};
  logic        t_we  [11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] t_wd  [11] = '{32'd0, 32'h1234_5678, 32'hAAAA_0001, 32'd0, 32'h0000_0005,
                              32'd0, 32'd0, 32'd0, 32'h0000_0041, 32'd0, 32'd0};

  initial begin
    bif.m0_req = 1'b0; bif.m0_addr = 32'd0; bif.m0_we = 1'b0; bif.m0_wdata = 32'd0;
    bif.m1_req = 1'b0; bif.m1_addr = 32'd0; bif.m1_we = 1'b0; bif.m1_wdata = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bus_addr", bif.bus_addr, 32'd0);
    chk("rst_bus_we", {31'd0, bif.bus_we}, 32'd0);
    chk("rst_bus_wdata", bif.bus_wdata, 32'd0);
    chk("rst_rdata", bif.rdata, 32'd0);
    chk("rst_acks", {30'd0, bif.m0_ack, bif.m1_ack}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Round robin straight out of reset: M0 twice back-to-back against one M1.
    ord.push_back(0); ord.push_back(1); ord.push_back(0);
    fork
      begin
        issue(0, 32'h0000_2100, 1'b1, 32'h0000_0001, 1'b1);
        issue(0, 32'h0000_0020, 1'b0, 32'd0, 1'b0);
      end
      issue(1, 32'h0000_2200, 1'b1, 32'h0000_0002, 1'b0);
    join

    // Single-master accesses across the map, including every rejection case.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      issue(t_m[i], t_addr[i], t_we[i], t_wd[i], 1'b1);
    end

    // Reset in the middle of a RAM write: bus_we drops at once, no ack.
    @(negedge clk);
    bif.m1_addr = 32'h0000_2010; bif.m1_we = 1'b1; bif.m1_wdata = 32'hCAFE_0000;
    bif.m1_req = 1'b1;
    @(negedge clk);
    chk("mid_access_we", {31'd0, bif.bus_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_we", {31'd0, bif.bus_we}, 32'd0);
    chk("async_rst_ack", {31'd0, bif.m1_ack}, 32'd0);
    bif.m1_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst2_bus_addr", bif.bus_addr, 32'd0);
    chk("rst2_rdata", bif.rdata, 32'd0);
    last_rd = 32'd0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_ack", {30'd0, bif.m0_ack, bif.m1_ack}, 32'd0);
    issue(1, 32'h0000_3000, 1'b0, 32'd0, 1'b1);

    // Tie after M1 was last granted: M0 first, then M1.
    @(negedge clk);
    ord.push_back(0); ord.push_back(1);
    fork
      issue(0, 32'h0000_2300, 1'b1, 32'h0000_0033, 1'b1);
      issue(1, 32'h0000_2304, 1'b0, 32'd0, 1'b0);
    join

    repeat (4) @(negedge clk);
    chk("q_drained", q0.size() + q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    chk("global_timeout", 32'd0, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "simulation time limit reached");
  end

endmodule
